// File: rtl/id_ex_pipe_pkg.sv
// id_ex_pipe_pkg: shared widths, ALU op encodings and control bundle for the ID/EX stage
package id_ex_pipe_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 16;
  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_RTYPE = 2'b10,
    ALU_IMM   = 2'b11
  } alu_op_e;
  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       reg_dst;
    logic [1:0] alu_op;
  } ctrl_t;
endpackage

// File: rtl/id_ex_pipe_load_use_detect.sv
// load_use_detect: flags an ID instruction reading the register a load in EX is about to write
module load_use_detect
  import id_ex_pipe_pkg::*;
(
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [ADDR_W-1:0] ex_rt_addr,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs_addr,
  input  logic [ADDR_W-1:0] id_rt_addr,
  output logic              hazard
);
  assign hazard = ex_valid & ex_mem_read & id_valid & (ex_rt_addr != '0) &
                  ((ex_rt_addr == id_rs_addr) | (ex_rt_addr == id_rt_addr));
endmodule

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID/EX pipeline register with load-use bubble insertion, stall hold and bubble counter
module id_ex_pipe
  import id_ex_pipe_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] ID_pc_i,
  input  logic [DATA_W-1:0] ID_rsData_i,
  input  logic [DATA_W-1:0] ID_rtData_i,
  input  logic [DATA_W-1:0] ID_imm_i,
  input  logic [ADDR_W-1:0] ID_rsAddr_i,
  input  logic [ADDR_W-1:0] ID_rtAddr_i,
  input  logic [ADDR_W-1:0] ID_rdAddr_i,
  input  logic              ID_valid_i,
  input  logic              ID_regWrite_i,
  input  logic              ID_memToReg_i,
  input  logic              ID_memRead_i,
  input  logic              ID_memWrite_i,
  input  logic              ID_aluSrc_i,
  input  logic              ID_regDst_i,
  input  logic [1:0]        ID_aluOp_i,
  input  logic              memStall_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] EX_pc_o,
  output logic [DATA_W-1:0] EX_rsData_o,
  output logic [DATA_W-1:0] EX_rtData_o,
  output logic [DATA_W-1:0] EX_imm_o,
  output logic [ADDR_W-1:0] EX_rsAddr_o,
  output logic [ADDR_W-1:0] EX_rtAddr_o,
  output logic [ADDR_W-1:0] EX_rdAddr_o,
  output logic              EX_valid_o,
  output logic              EX_regWrite_o,
  output logic              EX_memToReg_o,
  output logic              EX_memRead_o,
  output logic              EX_memWrite_o,
  output logic              EX_aluSrc_o,
  output logic              EX_regDst_o,
  output logic [1:0]        EX_aluOp_o,
  output logic              hazard_o,
  output logic [CNT_W-1:0]  bubbleCnt_o
);
  logic [CTRL_W-1:0] ctrl_q;
  ctrl_t ex_ctrl;
  logic bubble;
  assign ex_ctrl = ctrl_t'(ctrl_q);
  assign EX_regWrite_o = ex_ctrl.reg_write;
  assign EX_memToReg_o = ex_ctrl.mem_to_reg;
  assign EX_memRead_o  = ex_ctrl.mem_read;
  assign EX_memWrite_o = ex_ctrl.mem_write;
  assign EX_aluSrc_o   = ex_ctrl.alu_src;
  assign EX_regDst_o   = ex_ctrl.reg_dst;
  assign EX_aluOp_o    = ex_ctrl.alu_op;
  load_use_detect u_detect (
    .ex_valid   (EX_valid_o),
    .ex_mem_read(EX_memRead_o),
    .ex_rt_addr (EX_rtAddr_o),
    .id_valid   (ID_valid_i),
    .id_rs_addr (ID_rsAddr_i),
    .id_rt_addr (ID_rtAddr_i),
    .hazard     (hazard_o)
  );
  assign bubble = (hazard_o | flush_i) & ~memStall_i;
  // data fields follow ID even on a bubble so the squashed slot stays deterministic
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      EX_pc_o     <= '0;
      EX_rsData_o <= '0;
      EX_rtData_o <= '0;
      EX_imm_o    <= '0;
      EX_rsAddr_o <= '0;
      EX_rtAddr_o <= '0;
      EX_rdAddr_o <= '0;
      EX_valid_o  <= 1'b0;
      ctrl_q      <= '0;
      bubbleCnt_o <= '0;
    end else if (!memStall_i) begin
      EX_pc_o     <= ID_pc_i;
      EX_rsData_o <= ID_rsData_i;
      EX_rtData_o <= ID_rtData_i;
      EX_imm_o    <= ID_imm_i;
      EX_rsAddr_o <= bubble ? '0 : ID_rsAddr_i;
      EX_rtAddr_o <= bubble ? '0 : ID_rtAddr_i;
      EX_rdAddr_o <= bubble ? '0 : ID_rdAddr_i;
      EX_valid_o  <= ~bubble & ID_valid_i;
      ctrl_q      <= bubble ? '0 : {ID_regWrite_i, ID_memToReg_i, ID_memRead_i, ID_memWrite_i,
                                    ID_aluSrc_i, ID_regDst_i, ID_aluOp_i};
      if (bubble && bubbleCnt_o != '1) bubbleCnt_o <= bubbleCnt_o + 1'b1;
    end
  end
endmodule

// File: tb/tb_id_ex_pipe.sv
// tb_id_ex_pipe: directed scenarios plus random traffic checked every cycle against a behavioural model
module tb_id_ex_pipe;
  logic clk = 0, rst_i = 0;
  logic [31:0] ID_pc_i = 0, ID_rsData_i = 0, ID_rtData_i = 0, ID_imm_i = 0;
  logic [4:0] ID_rsAddr_i = 0, ID_rtAddr_i = 0, ID_rdAddr_i = 0;
  logic ID_valid_i = 0, ID_regWrite_i = 0, ID_memToReg_i = 0, ID_memRead_i = 0;
  logic ID_memWrite_i = 0, ID_aluSrc_i = 0, ID_regDst_i = 0;
  logic [1:0] ID_aluOp_i = 0;
  logic memStall_i = 0, flush_i = 0;
  logic [31:0] EX_pc_o, EX_rsData_o, EX_rtData_o, EX_imm_o;
  logic [4:0] EX_rsAddr_o, EX_rtAddr_o, EX_rdAddr_o;
  logic EX_valid_o, EX_regWrite_o, EX_memToReg_o, EX_memRead_o, EX_memWrite_o, EX_aluSrc_o, EX_regDst_o;
  logic [1:0] EX_aluOp_o;
  logic hazard_o;
  logic [15:0] bubbleCnt_o;
  int checks = 0, errors = 0;
  logic cmp_en = 0;

  id_ex_pipe dut (
    .clk_i(clk), .rst_i(rst_i),
    .ID_pc_i(ID_pc_i), .ID_rsData_i(ID_rsData_i), .ID_rtData_i(ID_rtData_i), .ID_imm_i(ID_imm_i),
    .ID_rsAddr_i(ID_rsAddr_i), .ID_rtAddr_i(ID_rtAddr_i), .ID_rdAddr_i(ID_rdAddr_i),
    .ID_valid_i(ID_valid_i), .ID_regWrite_i(ID_regWrite_i), .ID_memToReg_i(ID_memToReg_i),
    .ID_memRead_i(ID_memRead_i), .ID_memWrite_i(ID_memWrite_i), .ID_aluSrc_i(ID_aluSrc_i),
    .ID_regDst_i(ID_regDst_i), .ID_aluOp_i(ID_aluOp_i),
    .memStall_i(memStall_i), .flush_i(flush_i),
    .EX_pc_o(EX_pc_o), .EX_rsData_o(EX_rsData_o), .EX_rtData_o(EX_rtData_o), .EX_imm_o(EX_imm_o),
    .EX_rsAddr_o(EX_rsAddr_o), .EX_rtAddr_o(EX_rtAddr_o), .EX_rdAddr_o(EX_rdAddr_o),
    .EX_valid_o(EX_valid_o), .EX_regWrite_o(EX_regWrite_o), .EX_memToReg_o(EX_memToReg_o),
    .EX_memRead_o(EX_memRead_o), .EX_memWrite_o(EX_memWrite_o), .EX_aluSrc_o(EX_aluSrc_o),
    .EX_regDst_o(EX_regDst_o), .EX_aluOp_o(EX_aluOp_o),
    .hazard_o(hazard_o), .bubbleCnt_o(bubbleCnt_o)
  );

  always #5 clk = ~clk;

  // model state: what the EX stage must hold, per the stage rules
  logic [31:0] m_pc, m_rsd, m_rtd, m_imm;
  logic [4:0] m_rs, m_rt, m_rd;
  logic m_valid;
  logic [7:0] m_ctrl;
  logic [15:0] m_cnt;

  function automatic logic m_haz();
    return m_valid && m_ctrl[5] && ID_valid_i && m_rt != 0 && (m_rt == ID_rsAddr_i || m_rt == ID_rtAddr_i);
  endfunction

  always @(posedge clk) begin
    logic b;
    b = m_haz() || flush_i;
    if (rst_i) begin
      {m_pc, m_rsd, m_rtd, m_imm, m_rs, m_rt, m_rd, m_valid, m_ctrl, m_cnt} = '0;
    end else if (!memStall_i) begin
      m_pc = ID_pc_i; m_rsd = ID_rsData_i; m_rtd = ID_rtData_i; m_imm = ID_imm_i;
      if (b) begin
        m_rs = 0; m_rt = 0; m_rd = 0; m_valid = 0; m_ctrl = 0;
        if (m_cnt < 16'hFFFF) m_cnt = m_cnt + 1;
      end else begin
        m_rs = ID_rsAddr_i; m_rt = ID_rtAddr_i; m_rd = ID_rdAddr_i; m_valid = ID_valid_i;
        m_ctrl = {ID_regWrite_i, ID_memToReg_i, ID_memRead_i, ID_memWrite_i, ID_aluSrc_i, ID_regDst_i, ID_aluOp_i};
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) if (cmp_en) begin
    chk("pc", EX_pc_o, m_pc);
    chk("rsData", EX_rsData_o, m_rsd);
    chk("rtData", EX_rtData_o, m_rtd);
    chk("imm", EX_imm_o, m_imm);
    chk("addrs", {17'b0, EX_rsAddr_o, EX_rtAddr_o, EX_rdAddr_o}, {17'b0, m_rs, m_rt, m_rd});
    chk("valid", {31'b0, EX_valid_o}, {31'b0, m_valid});
    chk("ctrl", {24'b0, EX_regWrite_o, EX_memToReg_o, EX_memRead_o, EX_memWrite_o, EX_aluSrc_o, EX_regDst_o, EX_aluOp_o}, {24'b0, m_ctrl});
    chk("hazard", {31'b0, hazard_o}, {31'b0, m_haz()});
    chk("bubbleCnt", {16'b0, bubbleCnt_o}, {16'b0, m_cnt});
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_id();
    {ID_pc_i, ID_rsData_i, ID_rtData_i, ID_imm_i, ID_rsAddr_i, ID_rtAddr_i, ID_rdAddr_i} = '0;
    {ID_valid_i, ID_regWrite_i, ID_memToReg_i, ID_memRead_i, ID_memWrite_i, ID_aluSrc_i, ID_regDst_i, ID_aluOp_i} = '0;
  endtask

  task automatic lw(input logic [4:0] rt);
    clr_id();
    ID_pc_i = 32'h100; ID_valid_i = 1; ID_memRead_i = 1; ID_memToReg_i = 1; ID_regWrite_i = 1;
    ID_aluSrc_i = 1; ID_rtAddr_i = rt; ID_rsAddr_i = 5'd1;
  endtask

  task automatic rand_id();
    ID_pc_i = $urandom; ID_rsData_i = $urandom; ID_rtData_i = $urandom; ID_imm_i = $urandom;
    ID_rsAddr_i = 5'($urandom_range(0, 3)); ID_rtAddr_i = 5'($urandom_range(0, 3)); ID_rdAddr_i = 5'($urandom);
    {ID_valid_i, ID_regWrite_i, ID_memToReg_i, ID_memRead_i, ID_memWrite_i, ID_aluSrc_i, ID_regDst_i, ID_aluOp_i} = 9'($urandom);
  endtask

  initial begin
    rst_i = 1; memStall_i = 1; flush_i = 1;
    cyc();
    cmp_en = 1;
    rst_i = 0; memStall_i = 0; flush_i = 0;
    ID_valid_i = 1; #1;
    chk("lit reset pc", EX_pc_o, 0);
    chk("lit reset valid", {31'b0, EX_valid_o}, 0);
    chk("lit reset cnt", {16'b0, bubbleCnt_o}, 0);
    chk("lit reset hazard", {31'b0, hazard_o}, 0);
    clr_id();
    ID_pc_i = 32'h10; ID_regWrite_i = 1; ID_rdAddr_i = 5'd3; ID_valid_i = 1;
    cyc();
    chk("lit load pc", EX_pc_o, 32'h10);
    chk("lit load regWrite", {31'b0, EX_regWrite_o}, 1);
    chk("lit load rd", {27'b0, EX_rdAddr_o}, 3);
    chk("lit load valid", {31'b0, EX_valid_o}, 1);
    chk("lit load hazard", {31'b0, hazard_o}, 0);
    lw(5'd8);
    cyc();
    clr_id(); ID_valid_i = 1; ID_rsAddr_i = 5'd8; ID_rtAddr_i = 5'd2; ID_pc_i = 32'h104; ID_regWrite_i = 1; #1;
    chk("lit luse hazard", {31'b0, hazard_o}, 1);
    cyc();
    chk("lit bubble valid", {31'b0, EX_valid_o}, 0);
    chk("lit bubble regWrite", {31'b0, EX_regWrite_o}, 0);
    chk("lit bubble rt", {27'b0, EX_rtAddr_o}, 0);
    chk("lit bubble cnt", {16'b0, bubbleCnt_o}, 1);
    chk("lit bubble hazard", {31'b0, hazard_o}, 0);
    cyc();
    chk("lit dep rs", {27'b0, EX_rsAddr_o}, 8);
    chk("lit dep valid", {31'b0, EX_valid_o}, 1);
    lw(5'd0);
    cyc();
    clr_id(); ID_valid_i = 1; #1;
    chk("lit r0 hazard", {31'b0, hazard_o}, 0);
    cyc();
    chk("lit r0 valid", {31'b0, EX_valid_o}, 1);
    chk("lit r0 cnt", {16'b0, bubbleCnt_o}, 1);
    lw(5'd8);
    cyc();
    clr_id(); ID_valid_i = 1; ID_rsAddr_i = 5'd8; memStall_i = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      ID_pc_i = $urandom; ID_imm_i = $urandom; #1;
      chk("lit stall pc", EX_pc_o, 32'h100);
      chk("lit stall rt", {27'b0, EX_rtAddr_o}, 8);
      chk("lit stall cnt", {16'b0, bubbleCnt_o}, 1);
      chk("lit stall hazard", {31'b0, hazard_o}, 1);
    end
    memStall_i = 0;
    cyc();
    chk("lit post-stall cnt", {16'b0, bubbleCnt_o}, 2);
    lw(5'd5);
    cyc();
    clr_id(); ID_valid_i = 1; ID_rtAddr_i = 5'd5; flush_i = 1; #1;
    chk("lit both hazard", {31'b0, hazard_o}, 1);
    cyc();
    flush_i = 0;
    chk("lit both cnt", {16'b0, bubbleCnt_o}, 3);
    chk("lit both valid", {31'b0, EX_valid_o}, 0);
    lw(5'd7);
    cyc();
    rst_i = 1; memStall_i = 1;
    cyc();
    chk("lit rst-stall pc", EX_pc_o, 0);
    chk("lit rst-stall rt", {27'b0, EX_rtAddr_o}, 0);
    chk("lit rst-stall cnt", {16'b0, bubbleCnt_o}, 0);
    rst_i = 0; memStall_i = 0; clr_id(); ID_pc_i = 32'h44; ID_valid_i = 1;
    cyc();
    chk("lit post-rst pc", EX_pc_o, 32'h44);
    chk("lit post-rst valid", {31'b0, EX_valid_o}, 1);
    for (int i = 0; i < 3000; i++) begin
      rand_id();
      rst_i = ($urandom_range(0, 99) == 0);
      memStall_i = ($urandom_range(0, 7) == 0);
      flush_i = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) begin
        ID_valid_i = 1; ID_rsAddr_i = EX_rtAddr_o;
      end
      cyc();
    end
    rst_i = 1; memStall_i = 0; flush_i = 0;
    cyc();
    rst_i = 0; clr_id(); flush_i = 1;
    for (int i = 0; i < 65534; i++) cyc();
    chk("lit sat pre", {16'b0, bubbleCnt_o}, 32'hFFFE);
    cyc();
    chk("lit sat 1", {16'b0, bubbleCnt_o}, 32'hFFFF);
    cyc();
    chk("lit sat 2", {16'b0, bubbleCnt_o}, 32'hFFFF);
    flush_i = 0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_ex_pipe.md
ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk_i  in  1  rising-edge clock; rst_i  in  1  synchronous active-high reset.
REQ-002 The block SHALL have these ID-side inputs: ID_pc_i, ID_rsData_i, ID_rtData_i, ID_imm_i  in  32 each  decoded operands; ID_rsAddr_i, ID_rtAddr_i, ID_rdAddr_i  in  5 each  register addresses; ID_valid_i  in  1  ID holds a real instruction.
REQ-003 The block SHALL have these ID-side control inputs: ID_regWrite_i, ID_memToReg_i, ID_memRead_i, ID_memWrite_i, ID_aluSrc_i, ID_regDst_i  in  1 each; ID_aluOp_i  in  2.
REQ-004 The block SHALL have these pipeline-control inputs: memStall_i  in  1  data-memory busy, hold all stages; flush_i  in  1  squash the instruction entering EX.
REQ-005 The block SHALL have EX_* outputs that are registered copies of every REQ-002/003 input (same widths), plus EX_valid_o  out  1.
REQ-006 The block SHALL have hazard_o  out  1  load-use stall request to PC and IF/ID; bubbleCnt_o  out  16  count of inserted bubbles.

Function
REQ-007 Each cycle, the block SHALL apply exactly one update, in this priority order: rst_i > memStall_i > bubble > load.
REQ-008 Load: on a clock edge with no higher-priority condition, every EX_* register SHALL take its ID_* value, and EX_valid_o SHALL take ID_valid_i; latency is 1 cycle.
REQ-009 Hold: when memStall_i=1, all EX_* registers, EX_valid_o and bubbleCnt_o SHALL keep their values.
REQ-010 Bubble condition: bubble SHALL equal (hazard_o | flush_i) & ~memStall_i.
REQ-011 Bubble action: all control outputs, EX_valid_o, EX_rsAddr_o, EX_rtAddr_o and EX_rdAddr_o SHALL load 0; zeroed addresses guarantee no downstream forwarding match.
REQ-012 Bubble data: data fields (pc, rsData, rtData, imm) SHALL load their ID values; they are don't-care but kept deterministic.
REQ-013 hazard_o SHALL be combinational from registered state and ID inputs: EX_valid_o & EX_memRead_o & ID_valid_i & (EX_rtAddr_o != 0) & ((EX_rtAddr_o == ID_rsAddr_i) | (EX_rtAddr_o == ID_rtAddr_i)).
REQ-014 hazard_o SHALL remain asserted during memStall_i; the stalled instruction in ID re-evaluates after the stall releases.
REQ-015 A load-use hazard SHALL produce exactly one bubble: after the bubble, EX_memRead_o=0, so hazard_o drops and the held ID instruction loads next cycle.
REQ-016 flush_i and hazard_o asserted together SHALL insert one bubble and increment bubbleCnt_o once.
REQ-017 bubbleCnt_o SHALL increment by 1 on each bubble edge and saturate at 16'hFFFF, with no wrap.
REQ-018 The block SHALL create no combinational path from memStall_i or flush_i to hazard_o.

Reset
REQ-019 On rst_i=1 at a clock edge, all EX_* outputs, EX_valid_o and bubbleCnt_o SHALL become 0, regardless of memStall_i or flush_i.
REQ-020 Reset asserted mid-stall or mid-bubble SHALL discard the held instruction; the first edge after rst_i=0 loads normally.
REQ-021 While state is reset, hazard_o SHALL be 0.

Structure
REQ-022 A shared package SHALL hold: the aluOp encodings; a control-bundle width constant (8 bits); register-address width (5); data width (32); and the counter width (16).
REQ-023 Load-use detection SHALL be a sub-module load_use_detect (pure combinational, REQ-013); the pipeline registers and counter SHALL live in id_ex_pipe.

Verification
REQ-024 Scenario: reset, then ID_pc_i=32'h0000_0010, ID_regWrite_i=1, ID_rdAddr_i=5'd3, ID_valid_i=1 -> next cycle EX_pc_o=32'h10, EX_regWrite_o=1, EX_rdAddr_o=3, EX_valid_o=1, hazard_o=0.
REQ-025 Scenario: lw loaded with EX_rtAddr_o=5'd8, then ID_rsAddr_i=5'd8 -> hazard_o=1 that cycle; next edge EX_valid_o=0, EX_regWrite_o=0, EX_rtAddr_o=0, bubbleCnt_o=1; following edge the dependent instruction loads and hazard_o=0.
REQ-026 Scenario: lw with EX_rtAddr_o=0 and ID_rsAddr_i=0 -> hazard_o=0 and no bubble.
REQ-027 Scenario: memStall_i=1 for 3 cycles with ID inputs changing -> EX_* constant for 3 cycles, bubbleCnt_o unchanged; hazard_o stays 1 if the REQ-013 condition holds.
REQ-028 Scenario: flush_i=1 and hazard_o=1 in the same cycle -> one bubble, bubbleCnt_o +1; separately, with bubbleCnt_o preset to 16'hFFFE, two bubbles -> 16'hFFFF, 16'hFFFF.
REQ-029 Scenario: rst_i=1 during memStall_i=1 -> next cycle all outputs 0; then memStall_i=0, rst_i=0 -> normal load.
